// File: rtl/ctrl_escritura_banco.sv
// Write-port controller and scoreboard for the 32x32 register bank.
// Two write-back requesters (ALU = A, memory = M) share one bank write port through a
// round-robin arbiter; a per-register busy mask tracks reserved destinations for hazard stalls.
module ctrl_escritura_banco #(
   parameter int unsigned NREG = 32,
   parameter int unsigned AW   = 5,
   parameter int unsigned DW   = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            res_valid,
   input  logic [AW-1:0]   res_reg,
   input  logic            a_valid,
   input  logic [AW-1:0]   a_reg,
   input  logic [DW-1:0]   a_data,
   output logic            a_ready,
   input  logic            m_valid,
   input  logic [AW-1:0]   m_reg,
   input  logic [DW-1:0]   m_data,
   output logic            m_ready,
   output logic            RegEn,
   output logic [AW-1:0]   WriteReg,
   output logic [DW-1:0]   WriteData,
   input  logic [AW-1:0]   ReadReg1,
   input  logic [AW-1:0]   ReadReg2,
   output logic            stall,
   output logic [NREG-1:0] busy
);

   typedef enum logic {GrantA = 1'b0, GrantM = 1'b1} grant_e;

   grant_e          last_q, last_d;
   logic            reg_en_q, reg_en_d;
   logic [AW-1:0]   write_reg_q, write_reg_d;
   logic [DW-1:0]   write_data_q, write_data_d;
   logic [NREG-1:0] busy_q, busy_d;

   // Round-robin ready and hazard detection, purely combinational from current state.
   always_comb begin
      a_ready = a_valid & (~m_valid | (last_q == GrantM));
      m_ready = m_valid & (~a_valid | (last_q == GrantA));
      stall   = (busy_q[ReadReg1] & (ReadReg1 != '0))
              | (busy_q[ReadReg2] & (ReadReg2 != '0))
              | (res_valid & busy_q[res_reg] & (res_reg != '0));
   end

   // Next-state: launch the accepted write, update the grant history and the scoreboard.
   always_comb begin
      last_d       = last_q;
      reg_en_d     = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (a_ready) begin
         last_d       = GrantA;
         reg_en_d     = (a_reg != '0);
         write_reg_d  = a_reg;
         write_data_d = a_data;
      end else if (m_ready) begin
         last_d       = GrantM;
         reg_en_d     = (m_reg != '0);
         write_reg_d  = m_reg;
         write_data_d = m_data;
      end

      // Clear first so a same-edge reservation of the committing register wins.
      busy_d = busy_q;
      if (reg_en_q) begin
         busy_d[write_reg_q] = 1'b0;
      end
      if (res_valid && (res_reg != '0)) begin
         busy_d[res_reg] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State registers with synchronous reset; reset discards any write accepted at this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q       <= GrantM;
         reg_en_q     <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         busy_q       <= '0;
      end else begin
         last_q       <= last_d;
         reg_en_q     <= reg_en_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
      end
   end

   assign RegEn     = reg_en_q;
   assign WriteReg  = write_reg_q;
   assign WriteData = write_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ctrl_escritura_banco.sv
// Self-checking bench for ctrl_escritura_banco: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_ctrl_escritura_banco;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            res_valid;
   logic [AW-1:0]   res_reg;
   logic            a_valid;
   logic [AW-1:0]   a_reg;
   logic [DW-1:0]   a_data;
   logic            a_ready;
   logic            m_valid;
   logic [AW-1:0]   m_reg;
   logic [DW-1:0]   m_data;
   logic            m_ready;
   logic            RegEn;
   logic [AW-1:0]   WriteReg;
   logic [DW-1:0]   WriteData;
   logic [AW-1:0]   ReadReg1;
   logic [AW-1:0]   ReadReg2;
   logic            stall;
   logic [NREG-1:0] busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ctrl_escritura_banco #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .res_valid (res_valid),
      .res_reg   (res_reg),
      .a_valid   (a_valid),
      .a_reg     (a_reg),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .m_valid   (m_valid),
      .m_reg     (m_reg),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .RegEn     (RegEn),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .stall     (stall),
      .busy      (busy)
   );

   // Register bank stand-in driven by the controller's write port.
   logic [DW-1:0] bank [NREG];
   always @(posedge clk) begin
      if (RegEn) bank[WriteReg] <= WriteData;
   end

   // Reference model: pending-register set, who was served last, and the launched write.
   bit            mdl_busy [NREG];
   bit            mdl_last_a;
   bit            mdl_en;
   logic [AW-1:0] mdl_wreg;
   logic [DW-1:0] mdl_wdata;

   // 0 = nobody served, 1 = ALU, 2 = memory.
   function automatic int mdl_winner();
      if (a_valid && m_valid) return mdl_last_a ? 2 : 1;
      if (a_valid) return 1;
      if (m_valid) return 2;
      return 0;
   endfunction

   function automatic bit mdl_stall();
      bit s = 0;
      if (ReadReg1 != 0 && mdl_busy[ReadReg1]) s = 1;
      if (ReadReg2 != 0 && mdl_busy[ReadReg2]) s = 1;
      if (res_valid && res_reg != 0 && mdl_busy[res_reg]) s = 1;
      return s;
   endfunction

   function automatic logic [NREG-1:0] mdl_busy_vec();
      logic [NREG-1:0] v = '0;
      for (int i = 0; i < NREG; i++) v[i] = mdl_busy[i];
      return v;
   endfunction

   task automatic mdl_edge();
      int w = mdl_winner();
      if (reset) begin
         for (int i = 0; i < NREG; i++) mdl_busy[i] = 0;
         mdl_last_a = 0;
         mdl_en     = 0;
         mdl_wreg   = '0;
         mdl_wdata  = '0;
      end else begin
         if (mdl_en) mdl_busy[mdl_wreg] = 0;
         if (res_valid && res_reg != 0) mdl_busy[res_reg] = 1;
         if (w == 1) begin
            mdl_en = (a_reg != 0); mdl_wreg = a_reg; mdl_wdata = a_data; mdl_last_a = 1;
         end else if (w == 2) begin
            mdl_en = (m_reg != 0); mdl_wreg = m_reg; mdl_wdata = m_data; mdl_last_a = 0;
         end else begin
            mdl_en = 0;
         end
      end
   endtask

   // Advance one clock, keeping the model in step; returns 1 time unit after the edge.
   task automatic tick();
      mdl_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; a_valid = 1; m_valid = 1; a_reg = 5'd1; m_reg = 5'd2;
      a_data = 32'h1; m_data = 32'h2; res_valid = 0; ReadReg1 = 0; ReadReg2 = 0;
      tick(); tick();
      n_checks++; if (RegEn !== 1'b0) $display("FAIL reset RegEn got %0b want 0", RegEn);
      else n_pass++;
      n_checks++; if (busy !== '0) $display("FAIL reset busy got %h want 0", busy); else n_pass++;
      n_checks++; if (stall !== 1'b0) $display("FAIL reset stall got %0b want 0", stall);
      else n_pass++;
      n_checks++; if (WriteReg !== '0) $display("FAIL reset WriteReg got %0d want 0", WriteReg);
      else n_pass++;
      reset = 0; #1;
      n_checks++; if (a_ready !== 1'b1) $display("FAIL reset a_ready got %0b want 1", a_ready);
      else n_pass++;
      n_checks++; if (m_ready !== 1'b0) $display("FAIL reset m_ready got %0b want 0", m_ready);
      else n_pass++;
      a_valid = 0; m_valid = 0;
      tick();
   endtask

   task automatic test_contention();
      a_valid = 1; a_reg = 5'd3; a_data = 32'h11;
      m_valid = 1; m_reg = 5'd4; m_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (a_ready !== (i % 2 == 0) || m_ready !== (i % 2 == 1))
            $display("FAIL contention grant %0d: a_ready=%0b m_ready=%0b want A=%0b",
                     i, a_ready, m_ready, (i % 2 == 0));
         else n_pass++;
         tick();
         n_checks++;
         if (RegEn !== 1'b1 || WriteReg !== ((i % 2 == 0) ? 5'd3 : 5'd4) ||
             WriteData !== ((i % 2 == 0) ? 32'h11 : 32'h22))
            $display("FAIL contention write %0d: RegEn=%0b WriteReg=%0d WriteData=%h", i,
                     RegEn, WriteReg, WriteData);
         else n_pass++;
      end
      a_valid = 0; m_valid = 0;
      tick();
      n_checks++; if (RegEn !== 1'b0) $display("FAIL contention idle RegEn got %0b want 0", RegEn);
      else n_pass++;
   endtask

   task automatic test_raw_stall();
      res_valid = 1; res_reg = 5'd5;
      tick();
      res_valid = 0; ReadReg1 = 5'd5;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++; if (stall !== 1'b1) $display("FAIL raw stall wait %0d got %0b want 1", i, stall);
         else n_pass++;
         tick();
      end
      a_valid = 1; a_reg = 5'd5; a_data = 32'hDEADBEEF; #1;
      n_checks++; if (a_ready !== 1'b1) $display("FAIL raw a_ready got %0b want 1", a_ready);
      else n_pass++;
      tick();
      a_valid = 0;
      n_checks++;
      if (RegEn !== 1'b1 || WriteReg !== 5'd5 || stall !== 1'b1)
         $display("FAIL raw launch RegEn=%0b WriteReg=%0d stall=%0b want 1/5/1", RegEn, WriteReg,
                  stall);
      else n_pass++;
      tick();
      n_checks++; if (stall !== 1'b0) $display("FAIL raw release stall got %0b want 0", stall);
      else n_pass++;
      n_checks++;
      if (bank[5] !== 32'hDEADBEEF) $display("FAIL raw bank got %h want deadbeef", bank[5]);
      else n_pass++;
      ReadReg1 = 0;
   endtask

   task automatic test_reg0();
      res_valid = 1; res_reg = 5'd0; ReadReg2 = 5'd0;
      a_valid = 1; a_reg = 5'd0; a_data = 32'hFFFFFFFF; #1;
      n_checks++; if (a_ready !== 1'b1) $display("FAIL reg0 a_ready got %0b want 1", a_ready);
      else n_pass++;
      n_checks++; if (stall !== 1'b0) $display("FAIL reg0 stall got %0b want 0", stall);
      else n_pass++;
      tick();
      res_valid = 0; a_valid = 0;
      n_checks++;
      if (RegEn !== 1'b0 || busy[0] !== 1'b0)
         $display("FAIL reg0 RegEn=%0b busy0=%0b want 0/0", RegEn, busy[0]);
      else n_pass++;
   endtask

   task automatic test_collision();
      res_valid = 1; res_reg = 5'd7;
      tick();
      res_valid = 0; a_valid = 1; a_reg = 5'd7; a_data = 32'h77;
      tick();
      a_valid = 0; res_valid = 1; res_reg = 5'd7; #1;
      n_checks++;
      if (RegEn !== 1'b1 || WriteReg !== 5'd7 || stall !== 1'b1)
         $display("FAIL collision setup RegEn=%0b WriteReg=%0d stall=%0b want 1/7/1", RegEn,
                  WriteReg, stall);
      else n_pass++;
      tick();
      res_valid = 0;
      n_checks++; if (busy[7] !== 1'b1) $display("FAIL collision busy7 got %0b want 1", busy[7]);
      else n_pass++;
      a_valid = 1;
      tick();
      a_valid = 0;
      tick();
      n_checks++; if (busy !== '0) $display("FAIL collision drain busy got %h want 0", busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid_write();
      logic [DW-1:0] old9;
      res_valid = 1; res_reg = 5'd9;
      tick();
      res_valid = 0; old9 = bank[9];
      m_valid = 1; m_reg = 5'd9; m_data = 32'h99; reset = 1; #1;
      n_checks++; if (m_ready !== 1'b1) $display("FAIL midreset m_ready got %0b want 1", m_ready);
      else n_pass++;
      tick();
      reset = 0; m_valid = 0;
      n_checks++;
      if (RegEn !== 1'b0 || busy[9] !== 1'b0)
         $display("FAIL midreset RegEn=%0b busy9=%0b want 0/0", RegEn, busy[9]);
      else n_pass++;
      tick();
      n_checks++; if (bank[9] !== old9) $display("FAIL midreset bank9 got %h want %h", bank[9], old9);
      else n_pass++;
   endtask

   task automatic test_random();
      reset = 1; tick(); reset = 0;
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 29) == 0);
         res_valid = $urandom_range(0, 1) == 1;
         res_reg   = AW'($urandom_range(0, 7));
         a_valid   = $urandom_range(0, 2) != 0;
         a_reg     = AW'($urandom_range(0, 7));
         a_data    = $urandom;
         m_valid   = $urandom_range(0, 2) != 0;
         m_reg     = AW'($urandom_range(0, 7));
         m_data    = $urandom;
         ReadReg1  = AW'($urandom_range(0, 7));
         ReadReg2  = AW'($urandom_range(0, 7));
         #1;
         n_checks++;
         if (a_ready !== (mdl_winner() == 1) || m_ready !== (mdl_winner() == 2) ||
             stall !== mdl_stall())
            $display("FAIL random comb %0d: a_ready=%0b m_ready=%0b stall=%0b want %0b/%0b/%0b",
                     i, a_ready, m_ready, stall, mdl_winner() == 1, mdl_winner() == 2,
                     mdl_stall());
         else n_pass++;
         tick();
         n_checks++;
         if (RegEn !== mdl_en || WriteReg !== mdl_wreg || WriteData !== mdl_wdata ||
             busy !== mdl_busy_vec())
            $display("FAIL random state %0d: RegEn=%0b WriteReg=%0d WriteData=%h busy=%h want %0b/%0d/%h/%h",
                     i, RegEn, WriteReg, WriteData, busy, mdl_en, mdl_wreg, mdl_wdata,
                     mdl_busy_vec());
         else n_pass++;
      end
      reset = 0; res_valid = 0; a_valid = 0; m_valid = 0; ReadReg1 = 0; ReadReg2 = 0;
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) bank[i] = '0;
      reset = 1; res_valid = 0; res_reg = '0; a_valid = 0; a_reg = '0; a_data = '0;
      m_valid = 0; m_reg = '0; m_data = '0; ReadReg1 = '0; ReadReg2 = '0;
      @(posedge clk); #1;
      test_reset();
      test_contention();
      test_raw_stall();
      test_reg0();
      test_collision();
      test_reset_mid_write();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
